// File: rtl/ramp_timer.sv
// ---------------------------------------------------------------------------
// ramp_timer
//   Dual-slope ADC sequencer that feeds time_to_temp. Each conversion steps
//   through four phases:
//     1. Discharge the integrator.
//     2. Run-up on the sensor voltage for a fixed length.
//     3. One break-before-make guard cycle.
//     4. Run-down on the reference.
//   The run-down phase counts clock cycles until the synchronised comparator
//   trips. The count is then presented on down_ramp_time, together with a
//   one-cycle start pulse for the divider stage.
//
// Ports
//   clk             in   1   system clock
//   rst_n           in   1   asynchronous active-low reset
//   conv_req        in   1   start one conversion (sampled only in IDLE)
//   comp_in         in   1   async integrator comparator, 1 = above threshold
//   sw_reset        out  1   integrator discharge switch
//   sw_in           out  1   connects sensor voltage to integrator
//   sw_ref          out  1   connects negative reference to integrator
//   down_ramp_time  out  20  run-down cycle count, held until next result
//   start           out  1   1-cycle pulse, down_ramp_time valid same cycle
//   timeout         out  1   result saturated at MAX_DOWN
//   busy            out  1   high in every state except IDLE
// ---------------------------------------------------------------------------
module ramp_timer #(
    parameter logic [19:0] DISCHARGE_CYCLES = 20'd50_000,
    parameter logic [19:0] UP_CYCLES        = 20'd500_000,
    parameter logic [19:0] MAX_DOWN         = 20'hFFFFF,
    parameter bit          AUTO             = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        conv_req,
    input  logic        comp_in,
    output logic        sw_reset,
    output logic        sw_in,
    output logic        sw_ref,
    output logic [19:0] down_ramp_time,
    output logic        start,
    output logic        timeout,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISCHARGE,
        S_RUN_UP,
        S_GUARD,
        S_RUN_DOWN,
        S_DONE
    } state_t;

    state_t      state_reg,    state_next;
    logic [19:0] cnt_reg,      cnt_next;
    logic [19:0] down_reg,     down_next;
    logic        timeout_reg,  timeout_next;
    logic        start_reg,    start_next;
    logic        sw_reset_reg, sw_reset_next;
    logic        sw_in_reg,    sw_in_next;
    logic        sw_ref_reg,   sw_ref_next;
    logic        busy_reg,     busy_next;
    logic        comp_meta_reg;
    logic        comp_s_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            down_reg      <= '0;
            timeout_reg   <= 1'b0;
            start_reg     <= 1'b0;
            sw_reset_reg  <= 1'b1;
            sw_in_reg     <= 1'b0;
            sw_ref_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            comp_meta_reg <= 1'b0;
            comp_s_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            down_reg      <= down_next;
            timeout_reg   <= timeout_next;
            start_reg     <= start_next;
            sw_reset_reg  <= sw_reset_next;
            sw_in_reg     <= sw_in_next;
            sw_ref_reg    <= sw_ref_next;
            busy_reg      <= busy_next;
            comp_meta_reg <= comp_in;
            comp_s_reg    <= comp_meta_reg;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        down_next    = down_reg;
        timeout_next = timeout_reg;
        start_next   = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (AUTO || conv_req) begin
                    cnt_next   = '0;
                    state_next = S_DISCHARGE;
                end
            end
            S_DISCHARGE: begin
                if (cnt_reg == DISCHARGE_CYCLES - 20'd1) begin
                    cnt_next   = '0;
                    state_next = S_RUN_UP;
                end else begin
                    cnt_next = cnt_reg + 20'd1;
                end
            end
            S_RUN_UP: begin
                if (cnt_reg == UP_CYCLES - 20'd1) begin
                    cnt_next   = '0;
                    state_next = S_GUARD;
                end else begin
                    cnt_next = cnt_reg + 20'd1;
                end
            end
            S_GUARD: begin
                cnt_next   = '0;
                state_next = S_RUN_DOWN;
            end
            S_RUN_DOWN: begin
                // A comparator trip wins over a timeout in the same cycle,
                // so a trip landing exactly on MAX_DOWN is a valid result.
                if (!comp_s_reg) begin
                    down_next    = cnt_reg;
                    timeout_next = 1'b0;
                    start_next   = 1'b1;
                    state_next   = S_DONE;
                end else if (cnt_reg == MAX_DOWN) begin
                    down_next    = MAX_DOWN;
                    timeout_next = 1'b1;
                    start_next   = 1'b1;
                    state_next   = S_DONE;
                end else begin
                    cnt_next = cnt_reg + 20'd1;
                end
            end
            S_DONE: begin
                cnt_next   = '0;
                state_next = AUTO ? S_DISCHARGE : S_IDLE;
            end
            default: begin
                cnt_next   = '0;
                state_next = S_IDLE;
            end
        endcase

        // Switch and busy flops are loaded from the upcoming state. This
        // keeps them registered while still lining them up cycle-for-cycle
        // with the state they belong to. A guard state between RUN_UP and
        // RUN_DOWN guarantees that sw_in and sw_ref never touch.
        sw_reset_next = (state_next == S_IDLE) || (state_next == S_DISCHARGE);
        sw_in_next    = (state_next == S_RUN_UP);
        sw_ref_next   = (state_next == S_RUN_DOWN);
        busy_next     = (state_next != S_IDLE);
    end

    assign sw_reset       = sw_reset_reg;
    assign sw_in          = sw_in_reg;
    assign sw_ref         = sw_ref_reg;
    assign down_ramp_time = down_reg;
    assign start          = start_reg;
    assign timeout        = timeout_reg;
    assign busy           = busy_reg;

endmodule

// File: tb/tb_ramp_timer.sv
// ---------------------------------------------------------------------------
// tb_ramp_timer
//   Self-checking bench for ramp_timer, using two instances:
//     - dut   : manual mode (AUTO=0), driven by a table of comparator trip
//               times plus randomised trips.
//     - dut_a : AUTO=1 with a fixed 50-cycle trip, used to check the
//               back-to-back period.
//   A trip time k means comp_in is first sampled low at the k-th clock edge
//   after the edge that raised sw_ref (k = -1: comp_in low throughout).
// ---------------------------------------------------------------------------
module tb_ramp_timer;

    localparam int MAXD = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        conv_req;
    logic        comp_in;
    logic        sw_reset, sw_in, sw_ref, start, timeout, busy;
    logic [19:0] down_ramp_time;

    logic        conv_req_a;
    logic        comp_a;
    logic        sw_reset_a, sw_in_a, sw_ref_a, start_a, timeout_a, busy_a;
    logic [19:0] down_a;

    int total = 0;
    int bad   = 0;
    int overlap_errs = 0;
    logic prev_in = 1'b0, prev_ref = 1'b0, prev_in_a = 1'b0, prev_ref_a = 1'b0;

    always #5 clk = ~clk;

    ramp_timer #(
        .DISCHARGE_CYCLES(20'd10), .UP_CYCLES(20'd100),
        .MAX_DOWN(20'd1000), .AUTO(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .conv_req(conv_req), .comp_in(comp_in),
        .sw_reset(sw_reset), .sw_in(sw_in), .sw_ref(sw_ref),
        .down_ramp_time(down_ramp_time), .start(start),
        .timeout(timeout), .busy(busy)
    );

    ramp_timer #(
        .DISCHARGE_CYCLES(20'd10), .UP_CYCLES(20'd100),
        .MAX_DOWN(20'd1000), .AUTO(1'b1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .conv_req(conv_req_a), .comp_in(comp_a),
        .sw_reset(sw_reset_a), .sw_in(sw_in_a), .sw_ref(sw_ref_a),
        .down_ramp_time(down_a), .start(start_a),
        .timeout(timeout_a), .busy(busy_a)
    );

    // sw_in and sw_ref must never be high together or in adjacent cycles.
    always @(negedge clk) begin
        if (rst_n) begin
            if ((sw_in && sw_ref) || (sw_in && prev_ref) || (sw_ref && prev_in))
                overlap_errs <= overlap_errs + 1;
            if ((sw_in_a && sw_ref_a) || (sw_in_a && prev_ref_a) || (sw_ref_a && prev_in_a))
                overlap_errs <= overlap_errs + 1;
        end
        prev_in    <= sw_in;
        prev_ref   <= sw_ref;
        prev_in_a  <= sw_in_a;
        prev_ref_a <= sw_ref_a;
    end

    // Comparator for the AUTO instance: high outside run-down, drops so that
    // it is first sampled low 50 edges after sw_ref rises.
    initial begin
        int e;
        comp_a = 1'b1;
        e = -1;
        forever begin
            @(posedge clk);
            #1;
            if (sw_ref_a) begin
                e++;
                if (e == 49) comp_a = 1'b0;
            end else begin
                e = -1;
                comp_a = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Reference model: the result is the trip edge plus one (two sync stages,
    // minus one because the very first run-down cycle already checks),
    // saturating at MAXD with timeout set once the trip comes too late.
    function automatic void model(input int k, output int d, output int t);
        if (k < 0) begin
            d = 0; t = 0;
        end else if (k + 1 <= MAXD) begin
            d = k + 1; t = 0;
        end else begin
            d = MAXD; t = 1;
        end
    endfunction

    task automatic run_conv(input int k, input int exp_d, input int exp_t);
        int  n_in;
        int  e;
        bit  seen;
        bit  guard;
        bit  got;
        comp_in = (k < 0) ? 1'b0 : 1'b1;
        repeat (3) @(posedge clk);
        #1;
        conv_req = 1'b1;
        @(posedge clk);
        #1;
        conv_req = 1'b0;
        n_in = 0; seen = 0; guard = 0;
        for (int c = 0; c < 300 && !guard; c++) begin
            if (sw_in) begin
                n_in++;
                seen = 1;
            end else if (seen) begin
                guard = 1;
            end
            if (!guard) begin
                @(posedge clk);
                #1;
            end
        end
        check("guard_reached", {31'd0, guard}, 32'd1);
        if (!guard) return;
        check("sw_in_cycles", n_in, 100);
        check("guard_switches", {29'd0, sw_reset, sw_in, sw_ref}, 32'd0);
        e = -1; got = 0;
        while (!got && e < 1100) begin
            if (e == k - 1) comp_in = 1'b0;
            @(posedge clk);
            #1;
            e++;
            if (e == 0) check("sw_ref_after_guard", {31'd0, sw_ref}, 32'd1);
            if (start) got = 1;
        end
        check("start_seen", {31'd0, got}, 32'd1);
        if (!got) return;
        $display("conv k=%0d down=%0d timeout=%0d (expect %0d/%0d)",
                 k, down_ramp_time, timeout, exp_d, exp_t);
        check("down_ramp_time", {12'd0, down_ramp_time}, exp_d);
        check("timeout", {31'd0, timeout}, exp_t);
        @(posedge clk);
        #1;
        check("start_one_cycle", {31'd0, start}, 32'd0);
        check("busy_after_done", {31'd0, busy}, 32'd0);
        check("down_held", {12'd0, down_ramp_time}, exp_d);
    endtask

    typedef struct {
        int k;
        int exp_d;
        int exp_t;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int  n;
        int  k, d, t;
        bit  seen;
        vecs[0] = '{300, 301, 0};
        vecs[1] = '{-1, 0, 0};
        vecs[2] = '{2000, 1000, 1};
        vecs[3] = '{0, 1, 0};     // good conversion right after a timeout
        vecs[4] = '{999, 1000, 0};
        vecs[5] = '{1000, 1000, 1};
        vecs[6] = '{1, 2, 0};
        vecs[7] = '{50, 51, 0};

        conv_req   = 1'b0;
        conv_req_a = 1'b0;
        comp_in    = 1'b1;
        rst_n      = 1'b1;
        #1 rst_n   = 1'b0;
        #2;
        check("reset_outputs",
              {25'd0, sw_reset, sw_in, sw_ref, start, timeout, busy, 1'b0},
              {25'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        check("reset_down", {12'd0, down_ramp_time}, 32'd0);
        #20 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of RUN_UP aborts at once, with no start pulse.
        conv_req = 1'b1;
        @(posedge clk);
        #1;
        conv_req = 1'b0;
        n = 0;
        while (!sw_in && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (20) @(posedge clk);
        #1;
        check("in_run_up", {31'd0, sw_in}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_sw_in", {31'd0, sw_in}, 32'd0);
        check("rst_sw_reset", {31'd0, sw_reset}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        #12 rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (start || busy) seen = 1;
        end
        check("no_start_after_reset", {31'd0, seen}, 32'd0);

        foreach (vecs[i]) run_conv(vecs[i].k, vecs[i].exp_d, vecs[i].exp_t);

        for (int i = 0; i < 5; i++) begin
            k = int'($urandom_range(0, 1100));
            if ($urandom_range(0, 4) == 0) k = -1;
            model(k, d, t);
            run_conv(k, d, t);
        end

        // AUTO instance: back-to-back start pulses every 10+100+1+52+1 cycles.
        n = 0;
        while (!start_a && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("auto_first_start", {31'd0, start_a}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (!start_a && n < 400);
            $display("auto period=%0d down=%0d timeout=%0d", n, down_a, timeout_a);
            check("auto_period", n, 164);
            check("auto_down", {12'd0, down_a}, 32'd51);
            check("auto_timeout", {31'd0, timeout_a}, 32'd0);
        end

        check("switch_overlap", overlap_errs, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
